alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the MIPS datapath. It supersedes the single-cycle combinational ALU and keeps its eight logic and arithmetic ops, with registered single-cycle latency. It adds signed SLT, SLL/SRA, and iterative unsigned MULTU/DIVU producing hi/lo results, behind a valid/ready handshake on both sides. It sits in the EX stage; the control unit stalls the pipeline while `in_ready` is low.

---
 rtl/alu_pkg.sv | 41 ++++
 rtl/alu_muldiv_iter.sv | 118 +++++++++++
 rtl/alu_mc.sv | 186 ++++++++++++++++++
 tb/tb_alu_mc.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared opcodes, handshake FSM states and opcode helpers for
//                the multi-cycle ALU (alu_mc) and its iterative engine.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // Opcodes carried on ALU_operation; 11xx is illegal.
    localparam logic [3:0] OP_AND   = 4'b0000;
    localparam logic [3:0] OP_OR    = 4'b0001;
    localparam logic [3:0] OP_ADD   = 4'b0010;
    localparam logic [3:0] OP_XOR   = 4'b0011;
    localparam logic [3:0] OP_NOR   = 4'b0100;
    localparam logic [3:0] OP_SRL   = 4'b0101;
    localparam logic [3:0] OP_SUB   = 4'b0110;
    localparam logic [3:0] OP_SLT   = 4'b0111;
    localparam logic [3:0] OP_SLL   = 4'b1000;
    localparam logic [3:0] OP_SRA   = 4'b1001;
    localparam logic [3:0] OP_MULTU = 4'b1010;
    localparam logic [3:0] OP_DIVU  = 4'b1011;

    // Iterative engine mode select.
    localparam logic MODE_MUL = 1'b0;
    localparam logic MODE_DIV = 1'b1;

    // Handshake FSM states.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_e;

    // True for the opcodes that run on the iterative multiply/divide engine.
    function automatic logic is_iter(input logic [3:0] op);
        return (op == OP_MULTU) || (op == OP_DIVU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_iter.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_iter
//  Description : Bit-serial unsigned multiply (shift-add) and divide
//                (restoring) engine, one bit per cycle, WIDTH iterations.
//  Ports       : clk, rst      - clock, synchronous active-high reset
//                start         - load operands and begin (single-cycle pulse)
//                mode          - MODE_MUL / MODE_DIV
//                a, b          - multiplicand/multiplier, dividend/divisor
//                done          - high during the final iteration cycle
//                hi, lo        - result of the current step; valid with done
//                                (product hi/lo, or remainder/quotient)
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q, busy_d;
    logic             mode_q, mode_d;
    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [WIDTH-1:0] acc_q,  acc_d;   // partial product high half / remainder
    logic [WIDTH-1:0] sr_q,   sr_d;    // multiplier->product low / dividend->quotient
    logic [WIDTH-1:0] opnd_q, opnd_d;  // multiplicand / divisor

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_diff;
    logic [WIDTH-1:0] step_acc;
    logic [WIDTH-1:0] step_sr;

    // One iteration of the selected algorithm.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (sr_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        div_shift = {acc_q, sr_q[WIDTH-1]};
        div_diff  = div_shift - {1'b0, opnd_q};
        if (mode_q == MODE_DIV) begin
            // Remainder stays below the divisor, so the MSB of the difference
            // is a clean borrow flag: clear means the subtraction is kept.
            if (!div_diff[WIDTH]) begin
                step_acc = div_diff[WIDTH-1:0];
                step_sr  = {sr_q[WIDTH-2:0], 1'b1};
            end else begin
                step_acc = div_shift[WIDTH-1:0];
                step_sr  = {sr_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            // Add, then shift the 2*WIDTH product register right by one.
            step_acc = mul_sum[WIDTH:1];
            step_sr  = {mul_sum[0], sr_q[WIDTH-1:1]};
        end
    end

    always_comb begin
        busy_d = busy_q;
        mode_d = mode_q;
        cnt_d  = cnt_q;
        acc_d  = acc_q;
        sr_d   = sr_q;
        opnd_d = opnd_q;
        if (start) begin
            busy_d = 1'b1;
            mode_d = mode;
            cnt_d  = CW'(WIDTH - 1);
            acc_d  = '0;
            sr_d   = a;
            opnd_d = b;
        end else if (busy_q) begin
            acc_d = step_acc;
            sr_d  = step_sr;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= 1'b0;
            mode_q <= MODE_MUL;
            cnt_q  <= '0;
            acc_q  <= '0;
            sr_q   <= '0;
            opnd_q <= '0;
        end else begin
            busy_q <= busy_d;
            mode_q <= mode_d;
            cnt_q  <= cnt_d;
            acc_q  <= acc_d;
            sr_q   <= sr_d;
            opnd_q <= opnd_d;
        end
    end

    // The final step's result is handed out combinationally so the caller
    // can register it on the same edge that retires the engine.
    assign done = busy_q && (cnt_q == '0);
    assign hi   = step_acc;
    assign lo   = step_sr;

endmodule
`default_nettype wire

// File: rtl/alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : alu_mc
//  Description : Multi-cycle MIPS ALU with valid/ready handshake. Logic,
//                add/sub, compare and shift ops finish in one cycle; MULTU
//                and DIVU run on an iterative engine (WIDTH+1 cycle latency).
//  Ports       : clk, rst            - clock, synchronous active-high reset
//                in_valid/in_ready   - request handshake
//                A, B, ALU_operation - operands and opcode, sampled on accept
//                out_valid/out_ready - result handshake
//                res, res_hi         - result (lo/quotient), (hi/remainder)
//                zero, overflow      - res==0; signed ovf or divide-by-zero
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALU_operation,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic [WIDTH-1:0] res_hi,
    output logic             zero,
    output logic             overflow
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] res_q,    res_d;
    logic [WIDTH-1:0] res_hi_q, res_hi_d;
    logic             zero_q,   zero_d;
    logic             ovf_q,    ovf_d;

    logic             accept;
    logic             go_iter;
    logic             eng_start;
    logic             eng_mode;
    logic             eng_done;
    logic [WIDTH-1:0] eng_hi;
    logic [WIDTH-1:0] eng_lo;

    logic [WIDTH-1:0] add_sum;
    logic [WIDTH-1:0] sub_diff;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_ovf;

    // ------------------------------------------------------------------
    // Single-cycle datapath, evaluated on the live inputs and registered
    // on the accept edge.
    // ------------------------------------------------------------------
    always_comb begin
        add_sum  = A + B;
        sub_diff = A - B;
        shamt    = B[SHW-1:0];
        sc_res   = '0;
        sc_hi    = '0;
        sc_ovf   = 1'b0;
        case (ALU_operation)
            OP_AND: sc_res = A & B;
            OP_OR:  sc_res = A | B;
            OP_ADD: begin
                sc_res = add_sum;
                sc_ovf = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            OP_XOR: sc_res = A ^ B;
            OP_NOR: sc_res = ~(A | B);
            OP_SRL: sc_res = A >> shamt;
            OP_SUB: begin
                sc_res = sub_diff;
                sc_ovf = (A[WIDTH-1] != B[WIDTH-1]) && (sub_diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: sc_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLL: sc_res = A << shamt;
            OP_SRA: sc_res = $signed(A) >>> shamt;
            // Only reaches the single-cycle path when B is zero.
            OP_DIVU: begin
                sc_res = '1;
                sc_hi  = A;
                sc_ovf = 1'b1;
            end
            // MULTU never completes here; illegal opcodes yield all zeros.
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    assign in_ready  = !rst && ((state_q == S_IDLE) ||
                                ((state_q == S_DONE) && out_ready));
    assign accept    = in_valid && in_ready;
    // Divide-by-zero is resolved in one cycle without starting the engine.
    assign go_iter   = is_iter(ALU_operation) &&
                       !((ALU_operation == OP_DIVU) && (B == '0));
    assign eng_start = accept && go_iter;
    assign eng_mode  = (ALU_operation == OP_DIVU) ? MODE_DIV : MODE_MUL;

    alu_muldiv_iter #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (eng_start),
        .mode  (eng_mode),
        .a     (A),
        .b     (B),
        .done  (eng_done),
        .hi    (eng_hi),
        .lo    (eng_lo)
    );

    // ------------------------------------------------------------------
    // FSM next state and result registers. Results only load on entry to
    // DONE, so they stay stable while the consumer applies backpressure.
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        res_d    = res_q;
        res_hi_d = res_hi_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        if (accept) begin
            if (go_iter) begin
                state_d = S_ITER;
            end else begin
                state_d  = S_DONE;
                res_d    = sc_res;
                res_hi_d = sc_hi;
                zero_d   = (sc_res == '0);
                ovf_d    = sc_ovf;
            end
        end else begin
            case (state_q)
                S_ITER: begin
                    if (eng_done) begin
                        state_d  = S_DONE;
                        res_d    = eng_lo;
                        res_hi_d = eng_hi;
                        zero_d   = (eng_lo == '0);
                        ovf_d    = 1'b0;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            res_q    <= '0;
            res_hi_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            res_q    <= res_d;
            res_hi_q <= res_hi_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign out_valid = (state_q == S_DONE);
    assign res       = res_q;
    assign res_hi    = res_hi_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_mc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_mc
//  Description : Self-checking bench for alu_mc: directed corner cases,
//                backpressure / back-to-back streaming, reset mid-operation,
//                and randomized ops against an arithmetic reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_mc;

    localparam int WIDTH = 32;

    localparam logic [3:0] C_AND   = 4'b0000;
    localparam logic [3:0] C_ADD   = 4'b0010;
    localparam logic [3:0] C_XOR   = 4'b0011;
    localparam logic [3:0] C_SRL   = 4'b0101;
    localparam logic [3:0] C_SUB   = 4'b0110;
    localparam logic [3:0] C_SLT   = 4'b0111;
    localparam logic [3:0] C_SRA   = 4'b1001;
    localparam logic [3:0] C_MULTU = 4'b1010;
    localparam logic [3:0] C_DIVU  = 4'b1011;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_operation;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_hi;
    logic             zero;
    logic             overflow;

    int n_checks = 0;
    int n_fail   = 0;

    alu_mc #(.WIDTH(WIDTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .A             (A),
        .B             (B),
        .ALU_operation (ALU_operation),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .res           (res),
        .res_hi        (res_hi),
        .zero          (zero),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] hi;
        logic        zero;
        logic        ovf;
        logic [7:0]  lat;
    } exp_t;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on the operands.
    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa;
        longint      sb;
        longint      r;
        logic [63:0] p;
        int          sh;
        sa    = longint'($signed(a));
        sb    = longint'($signed(b));
        sh    = int'(b[4:0]);
        e.res = '0;
        e.hi  = '0;
        e.ovf = 1'b0;
        e.lat = 8'd1;
        case (op)
            4'd0: e.res = a & b;
            4'd1: e.res = a | b;
            4'd2: begin
                r     = sa + sb;
                e.res = r[31:0];
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd3: e.res = a ^ b;
            4'd4: e.res = ~(a | b);
            4'd5: e.res = a >> sh;
            4'd6: begin
                r     = sa - sb;
                e.res = r[31:0];
                e.ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
            end
            4'd7: e.res = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: e.res = a << sh;
            4'd9: begin
                r     = sa >>> sh;
                e.res = r[31:0];
            end
            4'd10: begin
                p     = {32'd0, a} * {32'd0, b};
                e.res = p[31:0];
                e.hi  = p[63:32];
                e.lat = 8'd33;
            end
            4'd11: begin
                if (b == 32'd0) begin
                    e.res = 32'hFFFF_FFFF;
                    e.hi  = a;
                    e.ovf = 1'b1;
                end else begin
                    e.res = a / b;
                    e.hi  = a % b;
                    e.lat = 8'd33;
                end
            end
            default: ;
        endcase
        e.zero = (e.res == 32'd0);
        return e;
    endfunction

    task automatic check_result(input string tag, input exp_t e);
        check({tag, "_valid"}, out_valid, 1'b1);
        check({tag, "_res"},   res,       e.res);
        check({tag, "_hi"},    res_hi,    e.hi);
        check({tag, "_zero"},  zero,      e.zero);
        check({tag, "_ovf"},   overflow,  e.ovf);
    endtask

    // Issue one op from idle, measure latency, hold under backpressure for a
    // random number of cycles, then retire. Called at posedge+1.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        int   lat;
        int   hold;
        logic busy_ok;
        e = model(op, a, b);
        A = a; B = b; ALU_operation = op; in_valid = 1'b1; out_ready = 1'b0;
        #1;
        check({tag, "_rdy"}, in_ready, 1'b1);
        lat     = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk); #1;
            if (lat == 0) begin
                // Operands must have been latched; scramble the inputs.
                in_valid      = 1'b0;
                A             = $urandom;
                B             = $urandom;
                ALU_operation = 4'($urandom);
            end
            lat++;
            if (!out_valid && in_ready) busy_ok = 1'b0;
        end while (!out_valid && lat < 100);
        check({tag, "_lat"}, 64'(lat), 64'(e.lat));
        if (e.lat > 8'd1) check({tag, "_busy_rdy"}, busy_ok, 1'b1);
        hold = $urandom_range(0, 3);
        for (int i = 0; i <= hold; i++) begin
            check_result(tag, e);
            check({tag, "_bp_rdy"}, in_ready, 1'b0);
            if (i < hold) begin
                @(posedge clk); #1;
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_retired"}, out_valid, 1'b0);
        out_ready = 1'b0;
    endtask

    initial begin
        exp_t        e_cur;
        logic [3:0]  op;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        stayed_quiet;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        A = '0; B = '0; ALU_operation = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid",  out_valid, 1'b0);
        check("rst_ready",  in_ready,  1'b0);
        check("rst_res",    res,       32'd0);
        check("rst_hi",     res_hi,    32'd0);
        check("rst_zero",   zero,      1'b0);
        check("rst_ovf",    overflow,  1'b0);
        rst = 1'b0;

        // Directed corner cases.
        run_op("add_ovf",  C_ADD,   32'h7FFF_FFFF, 32'd1);
        run_op("sub_zero", C_SUB,   32'd5,         32'd5);
        run_op("slt_neg",  C_SLT,   32'hFFFF_FFFF, 32'd1);
        run_op("sra",      C_SRA,   32'h8000_0000, 32'd4);
        run_op("srl",      C_SRL,   32'h8000_0000, 32'd4);
        run_op("mul_max",  C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("div",      C_DIVU,  32'd100,       32'd7);
        run_op("div0",     C_DIVU,  32'd9,         32'd0);
        run_op("illegal",  4'b1100, 32'h1234_5678, 32'h9ABC_DEF0);

        // Backpressure on an XOR result, then back-to-back streaming.
        ra = $urandom; rb = $urandom;
        e_cur = model(C_XOR, ra, rb);
        A = ra; B = rb; ALU_operation = C_XOR; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check_result("xor", e_cur);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check_result("xor_hold", e_cur);
            check("xor_hold_rdy", in_ready, 1'b0);
        end
        ra = $urandom; rb = $urandom;
        A = ra; B = rb; ALU_operation = C_AND; in_valid = 1'b1; out_ready = 1'b1;
        #1;
        check("b2b_rdy", in_ready, 1'b1);
        e_cur = model(C_AND, ra, rb);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            check_result("stream", e_cur);
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = $urandom;
            if (op == C_MULTU) op = C_ADD;
            if (op == C_DIVU)  rb = 32'd0;
            A = ra; B = rb; ALU_operation = op;
            e_cur = model(op, ra, rb);
        end
        @(posedge clk); #1;
        check_result("stream_last", e_cur);
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("stream_retired", out_valid, 1'b0);
        out_ready = 1'b0;

        // Reset in the middle of a MULTU.
        A = 32'hDEAD_BEEF; B = 32'h1234_5678; ALU_operation = C_MULTU; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1; in_valid = 1'b1; ALU_operation = C_ADD; A = 32'd1; B = 32'd1;
        #1;
        check("rstmid_rdy", in_ready, 1'b0);
        @(posedge clk); #1;
        check("rstmid_valid", out_valid, 1'b0);
        check("rstmid_res",   res,       32'd0);
        check("rstmid_hi",    res_hi,    32'd0);
        check("rstmid_zero",  zero,      1'b0);
        check("rstmid_ovf",   overflow,  1'b0);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        check("rstmid_idle_rdy", in_ready, 1'b1);
        stayed_quiet = 1'b1;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) stayed_quiet = 1'b0;
        end
        check("rstmid_aborted", stayed_quiet, 1'b1);
        run_op("add_after_rst", C_ADD, 32'd2, 32'd3);

        // Randomized ops.
        for (int n = 0; n < 50; n++) begin
            op = 4'($urandom_range(0, 15));
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'($urandom);
            run_op("rand", op, ra, rb);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
